pcileech_ft601_responder: RTL
=============================

# pcileech_ft601_responder

Synthesizable device-side model of the FT601 245-synchronous FIFO bus: the chip end of the link that pcileech_com drives as bus master. Host-to-FPGA words are queued from a stream port and presented to the master on reads. Master writes are captured with their byte enables and emitted on a second stream port. The block is used for on-board loopback self-test and simulation without a USB3 host, and it counts master protocol violations.

## Interface
- DEPTH, 512, entries in each internal FIFO; power of two, at least 4.
- ERR_W, 16, width of each violation counter.
- clk  in  1  FT601 bus clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ft601_data_in  in  32  bus value driven by the master during writes.
- ft601_data_out  out  32  bus value driven by this block during reads.
- ft601_data_oe  out  1  output enable for ft601_data_out; pad tristate lives outside.
- ft601_be_in  in  4  byte enables from the master during writes.
- ft601_rxf_n  out  1  low means read data is available to the master.
- ft601_txe_n  out  1  low means write space is available to the master.
- ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n  in  1 each  master strobes, active-low.
- h2f_data  in  32  host word to queue for the master.
- h2f_valid  in  1  h2f_data valid.
- h2f_ready  out  1  RX FIFO can accept a word.
- f2h_data  out  32  captured master write data.
- f2h_be  out  4  captured byte enables.
- f2h_valid  out  1  f2h word valid.
- f2h_ready  in  1  consumer accepts the f2h word.
- err_rd_empty  out  ERR_W  number of reads attempted while ft601_rxf_n was high.
- err_wr_full  out  ERR_W  number of writes attempted while ft601_txe_n was high.
- err_rd_no_oe  out  ERR_W  number of cycles with ft601_rd_n low and ft601_oe_n high.

## Operation
- **Reset values:** all outputs 0 except ft601_rxf_n=1 and ft601_txe_n=1. h2f_ready, f2h_valid, ft601_data_oe and all counters are 0. FIFO pointers and counts are cleared. An rst_n assertion mid-burst discards all queued data immediately.
- **RX FIFO (host to master):**
  - Push on a clock edge when h2f_valid and h2f_ready are both high.
  - Pop on an edge when ft601_oe_n, ft601_rd_n and ft601_rxf_n are all low.
  - Push and pop on the same edge leave the count unchanged.
  - h2f_ready is registered and equals count_next < DEPTH.
  - ft601_rxf_n is registered and equals count_next == 0.
- **ft601_data_out:** equals the RX FIFO head word whenever ft601_rxf_n is low. Its value when the FIFO is empty is don't-care.
- **ft601_data_oe:** registered, equals ~ft601_oe_n sampled on the previous edge. This models the chip's one-cycle bus turnaround.
- **TX FIFO (master to host):**
  - Capture {ft601_be_in, ft601_data_in} on an edge when ft601_wr_n and ft601_txe_n are both low.
  - Drain on an edge when f2h_valid and f2h_ready are both high.
  - ft601_txe_n is registered and equals count_next == DEPTH.
  - f2h_valid is registered and equals count_next != 0. f2h_data and f2h_be show the head entry.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, so both the full and empty states are representable.
- **Violations:**
  - A read attempt (oe_n=0, rd_n=0) while rxf_n=1 increments err_rd_empty and pops nothing.
  - A write attempt while txe_n=1 increments err_wr_full; the data is dropped.
  - Each cycle with rd_n=0 and oe_n=1 increments err_rd_no_oe; no pop occurs.
  - All counters saturate at 2^ERR_W-1.
- **ft601_siwu_n:** ignored.
- **Simultaneous rd_n and wr_n low:** both are serviced independently.

## Timing
- **Host to master:** a word pushed on edge k produces ft601_rxf_n=0 after edge k. The master may pop it at edge k+1.
- **Master to host:** a word written on edge k produces f2h_valid=1 after edge k.
- **Full-rate bursts:** one word per cycle in each direction with no bubbles. On the edge that pops the last entry, ft601_rxf_n goes high; a read on the next cycle is counted as a violation.
- **Full boundary:** on the edge that fills entry DEPTH, ft601_txe_n goes high. A concurrent drain on that same edge keeps txe_n low.
- **Reset release:** on the first edge after rst_n deasserts, ft601_txe_n goes to 0 and h2f_ready goes to 1.

## Test plan
- **Reset state:** assert rst_n=0 mid-burst with 5 words queued -> rxf_n=1, txe_n=1, counters 0. After release, txe_n=0 on the first edge and rxf_n stays 1.
- **Host to master:** push 0xA0000000..0xA0000007, then master burst-reads 8 words with oe_n low one cycle before rd_n -> data_out sequence matches the pushed order, and rxf_n rises on the edge of the 8th pop.
- **Master to host:** master writes 16 words with be=4'hF, then one word with be=4'h3; f2h_ready stays high -> f2h stream matches the written data and be, with 1-cycle latency.
- **Fill and wrap:** DEPTH=4, f2h_ready=0, master writes 5 words -> txe_n=1 after the 4th write, the 5th is dropped and err_wr_full=1. Then drain 2, write 2 more, drain all 4 -> order correct across the pointer wrap.
- **Read violations:** read with an empty FIFO for 3 cycles -> err_rd_empty=3. Hold rd_n=0 with oe_n=1 for 2 cycles -> err_rd_no_oe=2 and no pops.
- **Simultaneous traffic and saturation:** push and pop on the same edge with RX count at 1 -> count stays 1 and rxf_n stays 0. With ERR_W=2, cause 5 full-writes -> err_wr_full=3.

Source files
------------

// File: rtl/pcileech_ft601_responder.sv
// Device-side model of the FT601 245-synchronous FIFO bus: queues host words for master
// reads, captures master writes with byte enables, and counts master protocol violations.
module pcileech_ft601_responder #(
  parameter int DEPTH = 512,
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ft601_data_in,
  output logic [31:0]       ft601_data_out,
  output logic              ft601_data_oe,
  input  logic [3:0]        ft601_be_in,
  output logic              ft601_rxf_n,
  output logic              ft601_txe_n,
  input  logic              ft601_wr_n,
  input  logic              ft601_rd_n,
  input  logic              ft601_oe_n,
  input  logic              ft601_siwu_n,
  input  logic [31:0]       h2f_data,
  input  logic              h2f_valid,
  output logic              h2f_ready,
  output logic [31:0]       f2h_data,
  output logic [3:0]        f2h_be,
  output logic              f2h_valid,
  input  logic              f2h_ready,
  output logic [ERR_W-1:0]  err_rd_empty,
  output logic [ERR_W-1:0]  err_wr_full,
  output logic [ERR_W-1:0]  err_rd_no_oe
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v, input logic en);
    if (en && (v != {ERR_W{1'b1}})) return v + ERR_W'(1);
    return v;
  endfunction

  logic unused_siwu;
  assign unused_siwu = ft601_siwu_n;

  // Stage p0: bus qualification and next-state arithmetic
  logic rd_attempt_p0, rx_push_p0, rx_pop_p0;
  logic wr_attempt_p0, tx_push_p0, tx_pop_p0;
  logic v_rd_empty_p0, v_wr_full_p0, v_rd_no_oe_p0;
  cnt_t rx_cnt, rx_cnt_nxt_p0;
  cnt_t tx_cnt, tx_cnt_nxt_p0;
  ptr_t rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;

  logic [31:0] rx_mem [DEPTH];
  logic [35:0] tx_mem [DEPTH];
  logic [35:0] tx_head;

  assign rd_attempt_p0 = ~ft601_oe_n & ~ft601_rd_n;
  assign rx_push_p0    = h2f_valid & h2f_ready;
  assign rx_pop_p0     = rd_attempt_p0 & ~ft601_rxf_n;
  assign wr_attempt_p0 = ~ft601_wr_n;
  assign tx_push_p0    = wr_attempt_p0 & ~ft601_txe_n;
  assign tx_pop_p0     = f2h_valid & f2h_ready;

  assign v_rd_empty_p0 = rd_attempt_p0 & ft601_rxf_n;
  assign v_wr_full_p0  = wr_attempt_p0 & ft601_txe_n;
  assign v_rd_no_oe_p0 = ~ft601_rd_n & ft601_oe_n;

  assign rx_cnt_nxt_p0 = rx_cnt + cnt_t'(rx_push_p0) - cnt_t'(rx_pop_p0);
  assign tx_cnt_nxt_p0 = tx_cnt + cnt_t'(tx_push_p0) - cnt_t'(tx_pop_p0);

  // Stage p1: registered FIFO state, flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt        <= '0;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      h2f_ready     <= 1'b0;
      ft601_rxf_n   <= 1'b1;
      ft601_data_oe <= 1'b0;
    end else begin
      rx_cnt        <= rx_cnt_nxt_p0;
      if (rx_push_p0) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop_p0)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      h2f_ready     <= (rx_cnt_nxt_p0 < DEPTH_C);
      ft601_rxf_n   <= (rx_cnt_nxt_p0 == '0);
      ft601_data_oe <= ~ft601_oe_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt      <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      ft601_txe_n <= 1'b1;
      f2h_valid   <= 1'b0;
    end else begin
      tx_cnt      <= tx_cnt_nxt_p0;
      if (tx_push_p0) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop_p0)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      ft601_txe_n <= (tx_cnt_nxt_p0 == DEPTH_C);
      f2h_valid   <= (tx_cnt_nxt_p0 != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_rd_empty <= '0;
      err_wr_full  <= '0;
      err_rd_no_oe <= '0;
    end else begin
      err_rd_empty <= sat_inc(err_rd_empty, v_rd_empty_p0);
      err_wr_full  <= sat_inc(err_wr_full,  v_wr_full_p0);
      err_rd_no_oe <= sat_inc(err_rd_no_oe, v_rd_no_oe_p0);
    end
  end

  // Storage arrays carry data only, so they stay out of the reset domain
  always_ff @(posedge clk) begin
    if (rx_push_p0) rx_mem[rx_wr_ptr] <= h2f_data;
    if (tx_push_p0) tx_mem[tx_wr_ptr] <= {ft601_be_in, ft601_data_in};
  end

  assign ft601_data_out = rx_mem[rx_rd_ptr];
  assign tx_head        = tx_mem[tx_rd_ptr];
  assign f2h_data       = tx_head[31:0];
  assign f2h_be         = tx_head[35:32];

endmodule
